// File: rtl/wb_project_ctrl.sv
`timescale 1ns/1ps
// Wishbone-controlled project selector: drives a per-project enable vector
// and performs break-before-make switching between projects.
module wb_project_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [7:0]  GUARD_RST = 8'd4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        la_sel,
    input  logic [31:0] la_active_in,
    output logic [31:0] active,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_APPLY
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  guard_q, guard_d;
    logic [31:0] act_q, act_d;
    logic [31:0] tgt_q, tgt_d;
    logic        err_q, err_d;
    logic [4:0]  id_q, id_d;
    logic        off_q, off_d;

    logic        wr_q;
    logic [1:0]  woff_q;
    logic [31:0] wdat_q;
    logic [3:0]  wsel_q;

    logic        hit, req, idle;
    logic [1:0]  off;
    logic [31:0] rdata, status;
    logic        wr_act, wr_sel, wr_grd, wr_sts;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign hit  = wbs_stb_i & wbs_cyc_i
                & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // The ack cycle itself never starts a new access.
    assign req  = hit & ~wbs_ack_o;
    assign off  = wbs_adr_i[3:2];
    assign idle = (state_q == S_IDLE);

    assign status = {18'b0, off_q, id_q, 6'b0, err_q, ~idle};

    always_comb begin
        rdata = 32'h0;
        unique case (1'b1)
            (off == 2'd0): rdata = act_q;
            (off == 2'd2): rdata = {24'h0, guard_q};
            (off == 2'd3): rdata = status;
            default:       rdata = 32'h0;
        endcase
    end

    // Writes are applied on the edge that closes the ack cycle.
    assign wr_act = wr_q & (woff_q == 2'd0);
    assign wr_sel = wr_q & (woff_q == 2'd1);
    assign wr_grd = wr_q & (woff_q == 2'd2);
    assign wr_sts = wr_q & (woff_q == 2'd3);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            wr_q      <= 1'b0;
            woff_q    <= 2'd0;
            wdat_q    <= 32'h0;
            wsel_q    <= 4'h0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
            wr_q      <= req & wbs_we_i;
            if (req) begin
                woff_q <= off;
                wdat_q <= wbs_dat_i;
                wsel_q <= wbs_sel_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        guard_d = guard_q;
        act_d   = act_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        id_d    = id_q;
        off_d   = off_q;
        if (wr_sts && wdat_q[1]) err_d = 1'b0;
        if ((wr_act || wr_sel || wr_grd) && !idle) err_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (wr_act) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wsel_q[b]) act_d[8*b +: 8] = wdat_q[8*b +: 8];
                    end
                end
                if (wr_grd && wsel_q[0]) guard_d = wdat_q[7:0];
                if (wr_sel) begin
                    state_d = S_GUARD;
                    act_d   = 32'h0;
                    cnt_d   = guard_q;
                    tgt_d   = wdat_q[8] ? 32'h0 : (32'd1 << wdat_q[4:0]);
                    id_d    = wdat_q[4:0];
                    off_d   = wdat_q[8];
                end
            end
            S_GUARD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_APPLY;
                    act_d   = tgt_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_APPLY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            guard_q <= GUARD_RST;
            act_q   <= 32'h0;
            tgt_q   <= 32'h0;
            err_q   <= 1'b0;
            id_q    <= 5'd0;
            off_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
            act_q   <= act_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
            id_q    <= id_d;
            off_q   <= off_d;
        end
    end

    assign active = la_sel ? la_active_in : act_q;
    assign irq    = (state_q == S_APPLY);

endmodule

// File: tb/tb_wb_project_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for wb_project_ctrl: directed Wishbone accesses with
// queued read expectations checked by an independent ack monitor.
module tb_wb_project_ctrl;

    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_sel = 1'b0;
    logic [31:0] la_active_in = 32'h0;
    logic [31:0] active;
    logic        irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_ack = 1'b0;

    wb_project_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .la_sel      (la_sel),
        .la_active_in(la_active_in),
        .active      (active),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            check("ack_not_back_to_back", {31'h0, prev_ack}, 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'h1, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rd) check(mon_e.name, wbs_dat_o, mon_e.data);
            end
        end
        prev_ack = wbs_ack_o;
    end

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string name,
                      input logic [31:0] rexp, input bit acked = 1'b1);
        int   lat;
        exp_t e;
        @(posedge clk);
        #1;
        if (acked) begin
            e.rd   = !w;
            e.data = rexp;
            e.name = name;
            exp_q.push_back(e);
        end
        stb = 1'b1; cyc = 1'b1; we = w;
        adr = a; dat = d; sel = s;
        lat = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                lat = i;
                break;
            end
        end
        if (acked) begin
            check({name, "_latency"}, lat, 32'd1);
            @(posedge clk);
            #1;
        end else begin
            check({name, "_noack"}, lat, 32'hFFFF_FFFF);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic measure(input string name, input logic [31:0] tgt,
                           input int exp_zero);
        int z = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (active === 32'h0) z++;
            else break;
        end
        check({name, "_zero_cycles"}, z, exp_zero);
        check({name, "_target"}, active, tgt);
        check({name, "_irq_on"}, {31'h0, irq}, 32'h1);
        @(negedge clk);
        check({name, "_irq_off"}, {31'h0, irq}, 32'h0);
        check({name, "_held"}, active, tgt);
    endtask

    initial begin
        int irqs;
        int nz;
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", active, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        rst_n = 1'b1;

        wb(0, B + 32'hC, 0, 4'hF, "rd_status_rst", 32'h0);
        wb(0, B + 32'h8, 0, 4'hF, "rd_guard_rst", 32'h4);
        wb(0, B + 32'h4, 0, 4'hF, "rd_select_zero", 32'h0);

        wb(1, B, 32'hFFFF_FFFF, 4'b0010, "wr_active_lane1", 0);
        wb(0, B, 0, 4'hF, "rd_active_lane1", 32'h0000_FF00);
        check("active_lane1", active, 32'h0000_FF00);
        wb(1, B, 32'h1234_5678, 4'b1001, "wr_active_lane03", 0);
        wb(0, B, 0, 4'hF, "rd_active_lane03", 32'h1200_FF78);

        wb(0, B + 32'h10, 0, 4'hF, "rd_out_of_window", 0, 1'b0);
        wb(1, 32'h4000_0000, 32'h1, 4'hF, "wr_foreign", 0, 1'b0);
        check("active_after_foreign", active, 32'h1200_FF78);

        wb(1, B + 32'h4, 32'h0000_0009, 4'hF, "wr_select9", 0);
        measure("sel9", 32'h0000_0200, 5);
        wb(0, B + 32'hC, 0, 4'hF, "rd_status_sel9", 32'h0000_0900);

        wb(1, B + 32'h4, 32'h0000_0003, 4'hF, "wr_select3", 0);
        wb(1, B, 32'h0000_0001, 4'hF, "wr_active_busy", 0);
        repeat (10) @(negedge clk);
        check("active_sel3", active, 32'h0000_0008);
        wb(0, B, 0, 4'hF, "rd_active_sel3", 32'h0000_0008);
        wb(0, B + 32'hC, 0, 4'hF, "rd_status_err", 32'h0000_0302);
        wb(1, B + 32'hC, 32'h0000_0002, 4'hF, "wr_status_clr", 0);
        wb(0, B + 32'hC, 0, 4'hF, "rd_status_clr", 32'h0000_0300);

        wb(1, B + 32'h8, 32'h5A00_0000, 4'hF, "wr_guard0", 0);
        wb(0, B + 32'h8, 0, 4'hF, "rd_guard0", 32'h0);
        wb(1, B + 32'h4, 32'hFFFF_FE1F, 4'hF, "wr_select31", 0);
        measure("sel31", 32'h8000_0000, 1);
        wb(0, B + 32'hC, 0, 4'hF, "rd_status_sel31", 32'h0000_1F00);

        @(posedge clk);
        #1;
        la_sel = 1'b1;
        la_active_in = 32'hA5A5_A5A5;
        #1;
        check("la_mux", active, 32'hA5A5_A5A5);
        wb(0, B, 0, 4'hF, "rd_active_la", 32'h8000_0000);
        la_sel = 1'b0;
        #1;
        check("la_release", active, 32'h8000_0000);

        wb(1, B + 32'h4, 32'h0000_0100, 4'hF, "wr_alloff", 0);
        repeat (4) @(negedge clk);
        check("active_alloff", active, 32'h0);
        wb(0, B + 32'hC, 0, 4'hF, "rd_status_alloff", 32'h0000_2000);

        wb(1, B + 32'h8, 32'h0000_0007, 4'hF, "wr_guard7", 0);
        wb(1, B + 32'h4, 32'h0000_0005, 4'hF, "wr_select5", 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_active", active, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("midrst_dat", wbs_dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        irqs = 0;
        nz = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (irq) irqs++;
            if (active !== 32'h0) nz++;
        end
        check("midrst_no_irq", irqs, 32'h0);
        check("midrst_active_zero", nz, 32'h0);
        wb(0, B + 32'h8, 0, 4'hF, "rd_guard_after_rst", 32'h4);
        wb(0, B + 32'hC, 0, 4'hF, "rd_status_after_rst", 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_project_ctrl.md
WB_PROJECT_CTRL -- requirements
Module: wb_project_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address of the 16-byte register window.
REQ-002 SHALL have parameter GUARD_RST, default 8'd4, reset value of the GUARD register (break-before-make cycles).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_n  in  1  asynchronous active-low reset.
REQ-006 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write enable.
REQ-007 wbs_sel_i  in  4  byte lane enables.
REQ-008 wbs_adr_i, wbs_dat_i  in  32 each  Wishbone address and write data.
REQ-009 wbs_ack_o  out  1  Wishbone acknowledge; wbs_dat_o  out  32  read data.
REQ-010 la_sel  in  1  when high, active output follows la_active_in directly.
REQ-011 la_active_in  in  32  logic-analyser supplied active vector.
REQ-012 active  out  32  per-project enable vector feeding the wrapped project instances.
REQ-013 irq  out  1  one-cycle pulse on completion of a project switch.

Function
REQ-014 Register map (offset = wbs_adr_i[3:2]): 0 ACTIVE RW, 1 SELECT WO, 2 GUARD RW [7:0], 3 STATUS RO.
REQ-015 An access is decoded when stb&cyc are high and wbs_adr_i[31:4] == BASE_ADDR[31:4]; other addresses are never acked.
REQ-016 Ack is registered: wbs_ack_o high exactly one cycle after a decoded stb&cyc, low the following cycle, never two consecutive cycles.
REQ-017 Writes take effect on the ack cycle edge; read data is valid in wbs_dat_o while wbs_ack_o is high, 0 otherwise.
REQ-018 ACTIVE write in IDLE updates only byte lanes with wbs_sel_i set; effect is visible on active the cycle after ack.
REQ-019 SELECT write in IDLE starts a switch: data[8]=1 means "all off", else target = one-hot of data[4:0]; other bits ignored.
REQ-020 Switch FSM states: IDLE, GUARD, APPLY.
REQ-021 IDLE->GUARD on SELECT write: ACTIVE register cleared to 0, guard counter loaded with GUARD value.
REQ-022 GUARD: counter decrements by 1 per cycle; transition to APPLY on the cycle counter equals 0 (GUARD=0 gives one GUARD cycle).
REQ-023 APPLY (one cycle): ACTIVE <= target, irq high for that cycle, next state IDLE.
REQ-024 ACTIVE register is 0 for exactly GUARD+1 cycles between SELECT ack and the target appearing.
REQ-025 Writes to ACTIVE, SELECT or GUARD while not in IDLE are acked but discarded and set STATUS.err.
REQ-026 STATUS: [0] busy (state != IDLE), [1] err (sticky, cleared by writing STATUS with data[1]=1), [12:8] last selected id, [13] last select was "all off".
REQ-027 active = la_sel ? la_active_in : ACTIVE register, purely combinational mux; la_sel does not affect FSM or registers.
REQ-028 Reads of SELECT return 0; reads of ACTIVE return the register, not the muxed output.
REQ-029 A new access presented in the cycle an ack is issued is decoded normally from the next cycle.

Reset
REQ-030 On wb_rst_n low, immediately: ACTIVE=0, GUARD=GUARD_RST, FSM=IDLE, counter=0, err=0, STATUS id fields=0, wbs_ack_o=0, wbs_dat_o=0, irq=0.
REQ-031 Reset asserted mid-switch aborts it; after release target is not applied and active stays 0.
REQ-032 First access SHALL be accepted on the first clock edge after wb_rst_n deasserts.

Verification
REQ-033 Reset then read STATUS (offset 0xC) -> ack one cycle after stb, data 0x0000_0000; read GUARD -> 0x04.
REQ-034 Write ACTIVE 0xFFFF_FFFF with sel=4'b0010 -> read ACTIVE 0x0000_FF00, active output 0x0000_FF00.
REQ-035 Write SELECT 9 with GUARD=4 -> active 0 for 5 cycles, then 0x0000_0200, irq single pulse, STATUS[12:8]=9.
REQ-036 Write SELECT 3 then ACTIVE 0x1 while busy -> second write acked, discarded, STATUS.err=1; final active 0x8.
REQ-037 la_sel=1, la_active_in=0xA5A5_A5A5 -> active 0xA5A5_A5A5 same cycle; read ACTIVE unchanged.
REQ-038 Assert wb_rst_n low during GUARD -> all outputs 0 asynchronously, no irq, active 0 after release.
